// File: rtl/anc_pkg.sv
// Shared definitions for the noise-cancellation datapath: widths, the
// saturating clamp used by weight updates, and the LMS updater state type.
package anc_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WEIGHT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } lms_state_t;

  // Clamp a 33-bit signed sum into the signed 16-bit weight range.
  function automatic logic signed [WEIGHT_W-1:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)
      return 16'sh7FFF;
    else if (v < -33'sd32768)
      return 16'sh8000;
    else
      return v[WEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/lms_mac_sat.sv
// One LMS tap step: w_next = sat16(w + ((e * x) >>> MU_SHIFT)).
// Purely combinational so variants (leaky, normalized) can wrap it.
module lms_mac_sat
  import anc_pkg::*;
#(
  parameter int MU_SHIFT = 10
) (
  input  logic signed [SAMPLE_W-1:0] e,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [WEIGHT_W-1:0] w,
  output logic signed [WEIGHT_W-1:0] w_next
);

  logic signed [31:0] e_ext;
  logic signed [31:0] x_ext;
  logic signed [31:0] p;
  logic signed [31:0] d;
  logic signed [32:0] sum;

  // Full-precision product, floor-rounded step, 33-bit sum, then clamp.
  always_comb begin
    e_ext  = $signed({{(32-SAMPLE_W){e[SAMPLE_W-1]}}, e});
    x_ext  = $signed({{(32-SAMPLE_W){x[SAMPLE_W-1]}}, x});
    p      = e_ext * x_ext;
    d      = p >>> MU_SHIFT;
    sum    = $signed({{(33-WEIGHT_W){w[WEIGHT_W-1]}}, w}) + $signed({d[31], d});
    w_next = sat16(sum);
  end

endmodule

// File: rtl/lms_weight_updater.sv
// Sequential LMS weight updater: one tap per clock on each error strobe,
// reference-sample history in a circular buffer, registered weight read port.
module lms_weight_updater
  import anc_pkg::*;
#(
  parameter int NUM_TAPS = 32,
  parameter int MU_SHIFT = 10,
  localparam int AW      = $clog2(NUM_TAPS)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid_in,
  input  logic signed [SAMPLE_W-1:0] error_in,
  input  logic                       error_valid_in,
  input  logic                       error_locked_in,
  input  logic [AW-1:0]              weight_addr_in,
  output logic signed [WEIGHT_W-1:0] weight_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       overrun_out
);

  lms_state_t state, state_next;

  logic signed [WEIGHT_W-1:0] weights [NUM_TAPS];
  logic signed [SAMPLE_W-1:0] hist    [NUM_TAPS];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              k;
  logic [AW-1:0]              rd_idx;
  logic signed [SAMPLE_W-1:0] e_reg;
  logic signed [SAMPLE_W-1:0] skid_data;
  logic                       skid_full;
  logic                       overrun;
  logic                       accept;
  logic                       push_en;
  logic signed [SAMPLE_W-1:0] push_data;
  logic signed [WEIGHT_W-1:0] w_next;

  // x[n-k] lives k entries behind the most recent write.
  assign rd_idx = wr_ptr - AW'(1) - k;

  lms_mac_sat #(.MU_SHIFT(MU_SHIFT)) u_mac (
    .e      (e_reg),
    .x      (hist[rd_idx]),
    .w      (weights[k]),
    .w_next (w_next)
  );

  // State register.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block or statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus history push selection.
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    push_en    = 1'b0;
    push_data  = sample_in;
    case (state)
      IDLE: begin
        push_en = sample_valid_in;
        if (error_valid_in) begin
          accept     = !error_locked_in;
          state_next = error_locked_in ? DONE : UPDATE;
        end
      end
      UPDATE: begin
        if (k == AW'(NUM_TAPS - 1)) state_next = DONE;
      end
      DONE: begin
        // A push arriving now is newer than the skid entry and replaces it.
        push_en    = sample_valid_in || skid_full;
        push_data  = sample_valid_in ? sample_in : skid_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers: error latch, tap counter, skid entry, overrun flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      e_reg     <= '0;
      k         <= '0;
      skid_data <= '0;
      skid_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) begin
        e_reg <= error_in;
        k     <= '0;
      end else if (state == UPDATE) begin
        k <= k + AW'(1);
      end
      if (state == UPDATE && sample_valid_in) begin
        skid_data <= sample_in;
        skid_full <= 1'b1;
      end else if (state == DONE) begin
        skid_full <= 1'b0;
      end
      if (state != IDLE && error_valid_in) overrun <= 1'b1;
    end
  end

  // Weight and history arrays with their single write ports and the
  // registered (read-before-write) weight read port.
  // NOTE: these arrays are reset explicitly because a reset must leave no
  // stale taps or samples; that keeps them in flops rather than block RAM.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        weights[i] <= '0;
        hist[i]    <= '0;
      end
      wr_ptr     <= '0;
      weight_out <= '0;
    end else begin
      weight_out <= weights[weight_addr_in];
      if (state == UPDATE) weights[k] <= w_next;
      if (push_en) begin
        hist[wr_ptr] <= push_data;
        wr_ptr       <= wr_ptr + AW'(1);
      end
    end
  end

  assign busy_out    = (state != IDLE);
  assign done_out    = (state == DONE);
  assign overrun_out = overrun;

endmodule

// File: tb/tb_lms_weight_updater.sv
// Directed bench for lms_weight_updater with NUM_TAPS = 4, MU_SHIFT = 4.
module tb_lms_weight_updater;

  localparam int NUM_TAPS = 4;
  localparam int MU_SHIFT = 4;
  localparam int AW       = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic signed [15:0] error_in = '0;
  logic               error_valid = 1'b0;
  logic               error_locked = 1'b0;
  logic [AW-1:0]      weight_addr = '0;
  logic signed [15:0] weight_out;
  logic               busy;
  logic               done;
  logic               overrun;

  int checks   = 0;
  int failures = 0;

  lms_weight_updater #(.NUM_TAPS(NUM_TAPS), .MU_SHIFT(MU_SHIFT)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid),
    .error_in        (error_in),
    .error_valid_in  (error_valid),
    .error_locked_in (error_locked),
    .weight_addr_in  (weight_addr),
    .weight_out      (weight_out),
    .busy_out        (busy),
    .done_out        (done),
    .overrun_out     (overrun)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic signed [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic read_w(input int addr, output logic signed [15:0] v);
    weight_addr = AW'(addr);
    tick();
    v = weight_out;
  endtask

  task automatic check_weights(input string tag, input int e0, input int e1,
                               input int e2, input int e3);
    logic signed [15:0] v;
    int exp_w [4];
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    for (int i = 0; i < NUM_TAPS; i++) begin
      read_w(i, v);
      check($sformatf("%s_w%0d", tag, i), v, exp_w[i]);
    end
  endtask

  // Issue one error strobe (optionally with a same-cycle push), then measure
  // strobe-to-done latency and the number of busy cycles up to done.
  task automatic strobe(input string tag, input logic signed [15:0] e,
                        input logic locked, input logic do_push,
                        input logic signed [15:0] pv, input int exp_lat);
    int cnt;
    int busy_cnt;
    error_in     = e;
    error_locked = locked;
    error_valid  = 1'b1;
    sample_in    = pv;
    sample_valid = do_push;
    tick();
    error_valid  = 1'b0;
    error_locked = 1'b0;
    sample_valid = 1'b0;
    cnt      = 1;
    busy_cnt = 0;
    while (!done && cnt < 20) begin
      busy_cnt += int'(busy);
      tick();
      cnt++;
    end
    busy_cnt += int'(busy);
    check({tag, "_done_lat"}, cnt, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    tick();
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int done_cnt;
    logic signed [15:0] v;

    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_weight_out", weight_out, 0);
    rst = 1'b0;

    // 1. Basic update
    push(16); push(32); push(48); push(64);
    strobe("s1", 256, 1'b0, 1'b0, 0, 5);
    check_weights("s1", 1024, 768, 512, 256);

    // 2a. Build w[0] = 32000, then saturate high and low
    do_reset();
    push(512);
    strobe("s2a", 1000, 1'b0, 1'b0, 0, 5);
    read_w(0, v);
    check("s2a_w0_32000", v, 32000);
    push(32767);
    strobe("s2b", 32767, 1'b0, 1'b0, 0, 5);
    read_w(0, v);
    check("s2b_sat_hi", v, 32767);
    strobe("s2c", -32768, 1'b0, 1'b0, 0, 5);
    read_w(0, v);
    check("s2c_sat_lo", v, -32768);

    // 2b. Floor rounding: (-1 * 1) >>> 4 = -1 on every tap
    do_reset();
    push(1); push(1); push(1); push(1);
    strobe("s2d", -1, 1'b0, 1'b0, 0, 5);
    check_weights("s2d", -1, -1, -1, -1);

    // 3. Locked strobe: skipped, done after 1 cycle, weights frozen
    strobe("s3", 1000, 1'b1, 1'b0, 0, 1);
    check_weights("s3", -1, -1, -1, -1);

    // 4. Overrun and skid
    do_reset();
    push(16); push(32); push(48); push(64);
    error_in    = 256;
    error_valid = 1'b1;
    tick();
    error_valid = 1'b0;
    tick();
    error_in     = 9999;
    error_valid  = 1'b1;
    sample_in    = 7;
    sample_valid = 1'b1;
    tick();
    error_valid  = 1'b0;
    sample_valid = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      done_cnt += int'(done);
      tick();
    end
    check("s4_done_pulses", done_cnt, 1);
    check("s4_overrun_set", overrun, 1'b1);
    check_weights("s4a", 1024, 768, 512, 256);
    // history is now 7, 64, 48, 32 (newest first)
    strobe("s4b", 256, 1'b0, 1'b0, 0, 5);
    check_weights("s4b", 1136, 1792, 1280, 768);
    check("s4_overrun_sticky", overrun, 1'b1);

    // 5. Simultaneous push and strobe: 100 is x[n]
    strobe("s5", 16, 1'b0, 1'b1, 100, 5);
    check_weights("s5", 1236, 1799, 1344, 816);

    // 6. Reset mid-UPDATE
    do_reset();
    push(16); push(32); push(48); push(64);
    error_in    = 256;
    error_valid = 1'b1;
    tick();
    error_valid = 1'b0;
    tick();
    error_valid = 1'b1;
    tick();
    error_valid = 1'b0;
    check("s6_overrun_before_rst", overrun, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_busy", busy, 1'b0);
    check("s6_done", done, 1'b0);
    check("s6_overrun", overrun, 1'b0);
    check_weights("s6_cleared", 0, 0, 0, 0);
    push(16); push(32); push(48); push(64);
    strobe("s6_again", 256, 1'b0, 1'b0, 0, 5);
    check_weights("s6_again", 1024, 768, 512, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lms_weight_updater.md
# lms_weight_updater

Adaptive-coefficient engine for the noise-cancellation path. It consumes the error samples and `done_out` strobe produced by the error calculator and the reference-mic sample stream. On every error strobe it performs one sequential LMS update of the anti-noise FIR weights: one tap per clock, with a shift-based step size and saturating arithmetic. The anti-noise FIR filter reads weights through a registered read port. When the error calculator reports lock, the updater holds the weights frozen.

## Interface

Parameters:
- `NUM_TAPS`, default 32: number of FIR weights. Must be a power of two, ≥ 2.
- `MU_SHIFT`, default 10: step size μ = 2^-MU_SHIFT, applied as an arithmetic right shift.

Ports:
- `clk_in` — input, 1 bit: system clock.
- `rst_in` — input, 1 bit: reset. Synchronous, active-high.
- `sample_in` — input, signed 16 bits: reference-mic sample.
- `sample_valid_in` — input, 1 bit: single-cycle strobe that pushes `sample_in` into the history.
- `error_in` — input, signed 16 bits: error sample, driven by the error calculator `error_out`.
- `error_valid_in` — input, 1 bit: single-cycle strobe, driven by the error calculator `done_out`.
- `error_locked_in` — input, 1 bit: converged flag. While high, updates are suppressed.
- `weight_addr_in` — input, $clog2(NUM_TAPS) bits: read address for the FIR filter.
- `weight_out` — output, signed 16 bits: weight at `weight_addr_in`, available one cycle after the address.
- `busy_out` — output, 1 bit: high while an update is in progress.
- `done_out` — output, 1 bit: single-cycle pulse when an update completes or is skipped.
- `overrun_out` — output, 1 bit: sticky flag, set when an error strobe is dropped. Cleared only by reset.

## Operation

**History buffer**
- Circular buffer of NUM_TAPS signed 16-bit samples, written at `wr_ptr`.
- A push writes to `hist[wr_ptr]`, then increments `wr_ptr` modulo NUM_TAPS.
- x[n−k] is read from `hist[(wr_ptr − 1 − k) mod NUM_TAPS]`.

**FSM states:** IDLE, UPDATE, DONE.

- **IDLE**
  - `error_valid_in` && !`error_locked_in`: latch `error_in` into `e_reg`, set k = 0, go to UPDATE.
  - `error_valid_in` && `error_locked_in`: go to DONE. No weight writes.
- **UPDATE** (one tap per cycle)
  - p = e_reg × x[n−k], a 32-bit signed product.
  - d = p >>> MU_SHIFT, arithmetic shift (rounds toward −∞).
  - w[k] ← sat16(w[k] + d). The sum is computed at 33 bits, then clamped to [−32768, 32767].
  - After k = NUM_TAPS−1, go to DONE.
- **DONE**: assert `done_out` for one cycle, return to IDLE.

**Error strobes while busy**
- An `error_valid_in` in UPDATE or DONE is dropped and sets `overrun_out`.
- The update in progress is unaffected.

**Sample pushes**
- `sample_valid_in` in IDLE with no error strobe: applied the same cycle.
- `sample_valid_in` and `error_valid_in` in the same IDLE cycle: the push is applied first, so the new sample is x[n] for this update.
- `sample_valid_in` in UPDATE or DONE: captured in a one-entry skid register and committed on the cycle the FSM returns to IDLE.
  - A second push while the skid is full overwrites the skid. The older pending sample is lost.

**Reset**
- All weights, history entries, `wr_ptr`, the skid register, `e_reg` and k clear to 0. FSM goes to IDLE.
- Reset mid-UPDATE abandons the update. No partial state survives.
- Reset values of outputs: `weight_out` = 0, `busy_out` = 0, `done_out` = 0, `overrun_out` = 0.

## Timing

- Error strobe at cycle t in IDLE, unlocked:
  - `busy_out` is high for cycles t+1 … t+NUM_TAPS+1.
  - Tap k is written at the end of cycle t+1+k.
  - `done_out` is high in cycle t+NUM_TAPS+1 only.
  - A new strobe is accepted from cycle t+NUM_TAPS+2.
- Locked strobe at cycle t: `done_out` is high at t+1, with `busy_out` high only at t+1.
- Weight read latency is 1 cycle. A read of tap k in the same cycle tap k is written returns the old value (read-before-write).
- The design needs only one multiplier. The product is not pipelined; d is computed and written in the same cycle.

## Structure

- Shared package `anc_pkg`:
  - `SAMPLE_W` = 16 and `WEIGHT_W` = 16.
  - The `sat16` function.
  - The FSM state enum `lms_state_t`.
- Sub-module `lms_mac_sat`: purely combinational. Takes e, x, w and `MU_SHIFT`, returns the saturated new weight. It is reused by future leaky or normalized LMS variants.
- Weights and history are inferred register arrays or distributed RAM, each with one read port and one write port.

## Test plan

Unless noted, the bench uses NUM_TAPS = 4 and MU_SHIFT = 4.

1. **Basic update.** Push 16, 32, 48, 64, then strobe `error_in` = 256.
   - w[0..3] = 1024, 768, 512, 256.
   - `done_out` is high exactly 5 cycles after the strobe.
2. **Saturation and rounding.**
   - With w[0] = 32000, x[n] = 32767, e = 32767: w[0] = 32767.
   - With all weights 0, x = 1, e = −1: every weight = −1.
3. **Lock.** `error_locked_in` = 1 with `error_in` = 1000.
   - Weights unchanged.
   - `done_out` is high 1 cycle after the strobe.
   - `busy_out` is high for exactly 1 cycle.
4. **Overrun and skid.** A second error strobe 2 cycles after the first, and a sample push (value 7) during UPDATE.
   - `overrun_out` = 1 and stays set.
   - Only one `done_out` pulse.
   - 7 becomes x[n] for the next update.
5. **Simultaneous push and strobe in IDLE.** Push 100 in the same cycle as `error_in` = 16 (MU_SHIFT = 4): w[0] increases by exactly 100.
6. **Reset mid-UPDATE.** Assert `rst_in` during the 3rd update cycle.
   - All weights read 0 afterwards.
   - `busy_out`, `done_out` and `overrun_out` = 0.
   - A following update behaves as in scenario 1.
